cheat_pgm_sched: RTL and testbench

- Schedules all writes into the cheat engine's program port (pgm_idx/pgm_we/pgm_in).
- Two requesters share the port: the MCU single-entry write path, and a bulk loader that streams a cheat set from a BRAM table.
- Writes are held off while the SNES may be fetching a hooked vector or patched byte. Cheat registers therefore never change mid-read.
- Sits between the MCU command decoder and the cheat engine.

---
 rtl/cheat_pgm_sched.sv | 218 +++++++++++++++++++++
 tb/tb_cheat_pgm_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheat_pgm_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cheat_pgm_sched
// Purpose  : Arbitrates MCU and bulk-table writes onto the cheat program port,
//            holding writes off during the SNES fetch guard window.
//            Optional macro CHEAT_PGM_READBACK_EN adds a per-index readback
//            shadow (rd_idx / rd_data).
// Revision : 1.0 - initial release
// ============================================================================
module cheat_pgm_sched #(
    parameter int TBL_AW       = 4,
    parameter int GUARD_CYCLES = 6
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CHEAT_PGM_READBACK_EN
    input  logic [2:0]          rd_idx,
    output logic [31:0]         rd_data,
`endif
    input  logic                SNES_cycle_start,
    input  logic                SNES_reset_strobe,
    input  logic                mcu_req,
    input  logic [2:0]          mcu_idx,
    input  logic [31:0]         mcu_data,
    output logic                mcu_ack,
    input  logic                load_start,
    input  logic [TBL_AW:0]     load_len,
    output logic [TBL_AW-1:0]   tbl_addr,
    input  logic [34:0]         tbl_data,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_abort,
    output logic [2:0]          pgm_idx,
    output logic                pgm_we,
    output logic [31:0]         pgm_in
);

    localparam int c_GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [c_GW-1:0] c_GUARD_INIT = c_GW'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ISSUE = 3'd3,
        S_DEFER = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_GW-1:0]    r_guard_cnt;
    logic [TBL_AW:0]    r_len;
    logic [TBL_AW:0]    r_ptr;
    logic [2:0]         r_ent_idx;
    logic [31:0]        r_ent_data;
    logic               r_def_valid;
    logic [31:0]        r_def_data;
    logic               r_last_grant;   // 0 = MCU, 1 = bulk
    logic               r_mcu_ack;
    logic               r_load_done;
    logic               r_load_abort;
    logic [2:0]         r_pgm_idx;
    logic               r_pgm_we;
    logic [31:0]        r_pgm_in;

    logic               w_safe;
    logic               w_mcu_pend;
    logic               w_bulk_pend;
    logic               w_grant_bulk;
    logic               w_grant_mcu;
    logic               w_grant;
    logic [TBL_AW:0]    w_ptr_next;
    logic               w_last;
    logic [2:0]         w_bulk_idx;
    logic [31:0]        w_bulk_data;
    logic [2:0]         w_wr_idx;
    logic [31:0]        w_wr_data;

    assign w_safe      = (r_guard_cnt == '0) && !SNES_cycle_start;
    // The MCU still holds req during its ack cycle; that is not a new request.
    assign w_mcu_pend  = mcu_req && !r_mcu_ack;
    assign w_bulk_pend = ((r_state == S_ISSUE) || (r_state == S_DEFER)) && !SNES_reset_strobe;
    assign w_grant_bulk = w_safe && w_bulk_pend && (!w_mcu_pend || !r_last_grant);
    assign w_grant_mcu  = w_safe && w_mcu_pend && !w_grant_bulk;
    assign w_grant      = w_grant_bulk || w_grant_mcu;

    assign w_ptr_next  = r_ptr + 1'b1;
    assign w_last      = (w_ptr_next == r_len);
    assign w_bulk_idx  = (r_state == S_DEFER) ? 3'd7 : r_ent_idx;
    assign w_bulk_data = (r_state == S_DEFER) ? r_def_data : r_ent_data;
    assign w_wr_idx    = w_grant_mcu ? mcu_idx  : w_bulk_idx;
    assign w_wr_data   = w_grant_mcu ? mcu_data : w_bulk_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_guard_cnt  <= '0;
            r_len        <= '0;
            r_ptr        <= '0;
            r_ent_idx    <= '0;
            r_ent_data   <= '0;
            r_def_valid  <= 1'b0;
            r_def_data   <= '0;
            r_last_grant <= 1'b0;
            r_mcu_ack    <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_abort <= 1'b0;
            r_pgm_idx    <= '0;
            r_pgm_we     <= 1'b0;
            r_pgm_in     <= '0;
        end else begin
            if (SNES_cycle_start) begin
                r_guard_cnt <= c_GUARD_INIT;
            end else if (r_guard_cnt != '0) begin
                r_guard_cnt <= r_guard_cnt - 1'b1;
            end

            r_pgm_we    <= w_grant;
            r_mcu_ack   <= w_grant_mcu;
            r_load_done <= 1'b0;
            if (w_grant) begin
                r_pgm_idx    <= w_wr_idx;
                r_pgm_in     <= w_wr_data;
                r_last_grant <= w_grant_bulk;
            end

            if ((r_state != S_IDLE) && SNES_reset_strobe) begin
                r_state      <= S_IDLE;
                r_load_done  <= 1'b1;
                r_load_abort <= 1'b1;
                r_def_valid  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (load_start) begin
                            r_load_abort <= 1'b0;
                            if (load_len != '0) begin
                                r_len       <= load_len;
                                r_ptr       <= '0;
                                r_def_valid <= 1'b0;
                                r_state     <= S_FETCH;
                            end else begin
                                r_load_done <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: r_state <= S_LATCH;
                    S_LATCH: begin
                        // Global-enable entries are parked and written last.
                        if (tbl_data[34:32] == 3'd7) begin
                            r_def_data  <= tbl_data[31:0];
                            r_def_valid <= 1'b1;
                            if (w_last) begin
                                r_state <= S_DEFER;
                            end else begin
                                r_ptr   <= w_ptr_next;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_ent_idx  <= tbl_data[34:32];
                            r_ent_data <= tbl_data[31:0];
                            r_state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (w_grant_bulk) begin
                            r_ptr <= w_ptr_next;
                            if (w_last) begin
                                r_state <= r_def_valid ? S_DEFER : S_DONE;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_DEFER: begin
                        if (w_grant_bulk) begin
                            r_def_valid <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_load_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef CHEAT_PGM_READBACK_EN
    logic [31:0] r_shadow [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_grant) begin
            r_shadow[w_wr_idx] <= w_wr_data;
        end
    end

    assign rd_data = r_shadow[rd_idx];
`endif

    assign tbl_addr   = r_ptr[TBL_AW-1:0];
    assign load_busy  = (r_state != S_IDLE);
    assign load_done  = r_load_done;
    assign load_abort = r_load_abort;
    assign mcu_ack    = r_mcu_ack;
    assign pgm_idx    = r_pgm_idx;
    assign pgm_we     = r_pgm_we;
    assign pgm_in     = r_pgm_in;

endmodule
`default_nettype wire

// File: tb/tb_cheat_pgm_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cheat_pgm_sched
// Purpose  : Self-checking bench for cheat_pgm_sched (directed + random loads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cheat_pgm_sched;

    localparam int TBL_AW = 4;
    localparam int GUARD  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               SNES_cycle_start;
    logic               SNES_reset_strobe;
    logic               mcu_req;
    logic [2:0]         mcu_idx;
    logic [31:0]        mcu_data;
    logic               mcu_ack;
    logic               load_start;
    logic [TBL_AW:0]    load_len;
    logic [TBL_AW-1:0]  tbl_addr;
    logic [34:0]        tbl_data;
    logic               load_busy;
    logic               load_done;
    logic               load_abort;
    logic [2:0]         pgm_idx;
    logic               pgm_we;
    logic [31:0]        pgm_in;

    always #5 clk = ~clk;

    cheat_pgm_sched #(.TBL_AW(TBL_AW), .GUARD_CYCLES(GUARD)) dut (
        .clk               (clk),
        .rst               (rst),
        .SNES_cycle_start  (SNES_cycle_start),
        .SNES_reset_strobe (SNES_reset_strobe),
        .mcu_req           (mcu_req),
        .mcu_idx           (mcu_idx),
        .mcu_data          (mcu_data),
        .mcu_ack           (mcu_ack),
        .load_start        (load_start),
        .load_len          (load_len),
        .tbl_addr          (tbl_addr),
        .tbl_data          (tbl_data),
        .load_busy         (load_busy),
        .load_done         (load_done),
        .load_abort        (load_abort),
        .pgm_idx           (pgm_idx),
        .pgm_we            (pgm_we),
        .pgm_in            (pgm_in)
    );

    // Cheat-set table: synchronous BRAM, one clock read latency.
    logic [34:0] mem [16];
    always @(posedge clk) tbl_data <= mem[tbl_addr];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor state
    logic [34:0] bulk_q [$];
    int  last_bulk_cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  we_cnt = 0;
    int  last_start = -1000;
    bit  prev_safe = 1'b0;
    bit  prev_mcu_pend = 1'b0;
    bit  last_src_mcu = 1'b1;
    bit  done_busy = 1'b0;

    always @(negedge clk) begin
        if (pgm_we) begin
            we_cnt++;
            n_cmp++;
            assert (prev_safe === 1'b1) else begin
                n_err++;
                $error("FAIL guard_window: cycle %0d pgm_we=1 observed prev_safe=%0b expected 1", cyc, prev_safe);
            end
            if (!mcu_ack) begin
                bulk_q.push_back({pgm_idx, pgm_in});
                last_bulk_cyc = cyc;
                if (prev_mcu_pend) begin
                    n_cmp++;
                    assert (last_src_mcu === 1'b1) else begin
                        n_err++;
                        $error("FAIL alternation: cycle %0d bulk won contention, observed last_src_mcu=%0b expected 1", cyc, last_src_mcu);
                    end
                end
                last_src_mcu = 1'b0;
            end else begin
                last_src_mcu = 1'b1;
            end
        end
        if (mcu_ack) begin
            n_cmp++;
            assert (pgm_we === 1'b1) else begin
                n_err++;
                $error("FAIL ack_with_we: cycle %0d observed pgm_we=%0b expected 1", cyc, pgm_we);
            end
        end
        if (load_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = load_busy;
        end
        if (rst) begin
            last_start   = -1000;
            last_src_mcu = 1'b1;
        end else if (SNES_cycle_start) begin
            last_start = cyc;
        end
        prev_safe     = !SNES_cycle_start && ((cyc - last_start) >= GUARD + 1);
        prev_mcu_pend = mcu_req && !mcu_ack;
    end

    task automatic snes_gen(input int period, input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk); #1 SNES_cycle_start = 1'b1;
            @(posedge clk); #1 SNES_cycle_start = 1'b0;
            repeat (period - 2) @(posedge clk);
        end
    endtask

    task automatic mcu_write(input logic [2:0] idx, input logic [31:0] d, input int budget);
        int t;
        bit got;
        @(posedge clk); #1;
        mcu_req = 1'b1; mcu_idx = idx; mcu_data = d;
        got = 1'b0;
        t = 0;
        while (!got && t < budget) begin
            @(negedge clk);
            t++;
            if (mcu_ack) got = 1'b1;
        end
        n_cmp++;
        assert (got) else begin
            n_err++;
            $error("FAIL mcu_timeout: observed no ack in %0d cycles, expected ack", budget);
        end
        if (got) begin
            n_cmp++;
            assert ({pgm_we, pgm_idx, pgm_in} === {1'b1, idx, d}) else begin
                n_err++;
                $error("FAIL mcu_write: observed we=%0b idx=%0d data=%h expected we=1 idx=%0d data=%h",
                       pgm_we, pgm_idx, pgm_in, idx, d);
            end
        end
        @(posedge clk); #1 mcu_req = 1'b0;
    endtask

    // Reference: non-idx7 entries in table order, then the last idx7 entry.
    task automatic run_load(input int len, input int budget, input string tag);
        logic [34:0] exp_q [$];
        logic [34:0] d7;
        bit has7;
        int t;
        has7 = 1'b0;
        d7 = '0;
        for (int i = 0; i < len; i++) begin
            if (mem[i][34:32] == 3'd7) begin
                d7 = mem[i];
                has7 = 1'b1;
            end else begin
                exp_q.push_back(mem[i]);
            end
        end
        if (has7) exp_q.push_back(d7);
        bulk_q.delete();
        done_cnt = 0;
        @(posedge clk); #1 load_start = 1'b1; load_len = len[TBL_AW:0];
        @(posedge clk); #1 load_start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        assert (done_cnt > 0) else begin
            n_err++;
            $error("FAIL %s_done_timeout: observed no load_done in %0d cycles, expected pulse", tag, budget);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        assert (done_cnt === 1) else begin
            n_err++;
            $error("FAIL %s_done_count: observed %0d expected 1", tag, done_cnt);
        end
        n_cmp++;
        assert (bulk_q.size() === exp_q.size()) else begin
            n_err++;
            $error("FAIL %s_write_count: observed %0d expected %0d", tag, bulk_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < bulk_q.size(); i++) begin
            n_cmp++;
            assert (bulk_q[i] === exp_q[i]) else begin
                n_err++;
                $error("FAIL %s_write[%0d]: observed idx=%0d data=%h expected idx=%0d data=%h",
                       tag, i, bulk_q[i][34:32], bulk_q[i][31:0], exp_q[i][34:32], exp_q[i][31:0]);
            end
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            assert (done_cyc === last_bulk_cyc + 1) else begin
                n_err++;
                $error("FAIL %s_done_timing: observed cycle %0d expected %0d", tag, done_cyc, last_bulk_cyc + 1);
            end
        end
        n_cmp++;
        assert (done_busy === 1'b0) else begin
            n_err++;
            $error("FAIL %s_busy_at_done: observed %0b expected 0", tag, done_busy);
        end
        n_cmp++;
        assert (load_abort === 1'b0) else begin
            n_err++;
            $error("FAIL %s_abort_flag: observed %0b expected 0", tag, load_abort);
        end
    endtask

    task automatic fill_random(input int len, input bit allow7);
        for (int i = 0; i < len; i++) begin
            mem[i] = {3'(allow7 ? $urandom_range(0, 7) : $urandom_range(0, 6)), 32'($urandom)};
        end
    endtask

    initial begin
        logic [43:0] obs;
        int len;
        int snap;

        rst = 1'b1;
        SNES_cycle_start = 1'b0; SNES_reset_strobe = 1'b0;
        mcu_req = 1'b0; mcu_idx = '0; mcu_data = '0;
        load_start = 1'b0; load_len = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        obs = {mcu_ack, tbl_addr, load_busy, load_done, load_abort, pgm_idx, pgm_we, pgm_in};
        n_cmp++;
        assert (obs === 44'd0) else begin
            n_err++;
            $error("FAIL reset_state: observed %h expected 0", obs);
        end

        // Two-entry load, no SNES activity
        mem[0] = {3'd0, 32'h00FF_EA12};
        mem[1] = {3'd6, 32'h0000_003F};
        run_load(2, 100, "bulk2");

        // idx-7 deferral
        mem[0] = {3'd7, 32'h0000_0107};
        mem[1] = {3'd0, 32'hAAAA_0001};
        mem[2] = {3'd1, 32'hBBBB_0002};
        run_load(3, 100, "defer7");

        // Guard window: MCU writes with SNES cycles every 8 clk
        fork
            snes_gen(8, 12);
            begin
                mcu_write(3'd2, 32'h1234_5678, 40);
                mcu_write(3'd5, 32'hCAFE_F00D, 40);
                mcu_write(3'd7, 32'h0000_0001, 40);
            end
        join

        // Contention: MCU requesting continuously during a 4-entry load
        fill_random(4, 1'b0);
        fork
            run_load(4, 300, "contend");
            begin
                for (int i = 0; i < 6; i++) mcu_write(3'(i), 32'($urandom), 60);
            end
        join

        // Abort after the first write
        fill_random(4, 1'b0);
        mem[3][34:32] = 3'd7;
        bulk_q.delete();
        done_cnt = 0;
        @(posedge clk); #1 load_start = 1'b1; load_len = 5'd4;
        @(posedge clk); #1 load_start = 1'b0;
        for (int t = 0; t < 50 && bulk_q.size() == 0; t++) @(negedge clk);
        @(posedge clk); #1 SNES_reset_strobe = 1'b1;
        @(posedge clk); #1 SNES_reset_strobe = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        assert (bulk_q.size() === 1) else begin
            n_err++;
            $error("FAIL abort_writes: observed %0d expected 1", bulk_q.size());
        end
        n_cmp++;
        assert (done_cnt === 1) else begin
            n_err++;
            $error("FAIL abort_done: observed %0d expected 1", done_cnt);
        end
        n_cmp++;
        assert ({load_abort, load_busy} === 2'b10) else begin
            n_err++;
            $error("FAIL abort_flags: observed abort=%0b busy=%0b expected abort=1 busy=0", load_abort, load_busy);
        end

        // Zero-length load: one done pulse, no writes, clears load_abort
        run_load(0, 20, "zero_len");

        // rst while stuck in ISSUE behind the guard window
        fill_random(3, 1'b0);
        @(posedge clk); #1 load_start = 1'b1; load_len = 5'd3;
        @(posedge clk); #1 load_start = 1'b0; SNES_cycle_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 SNES_cycle_start = ~SNES_cycle_start;
        end
        snap = we_cnt;
        @(posedge clk); #1 rst = 1'b1; SNES_cycle_start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        obs = {mcu_ack, tbl_addr, load_busy, load_done, load_abort, pgm_idx, pgm_we, pgm_in};
        n_cmp++;
        assert (obs === 44'd0) else begin
            n_err++;
            $error("FAIL rst_mid_issue: observed %h expected 0", obs);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        assert (we_cnt === snap) else begin
            n_err++;
            $error("FAIL rst_no_write: observed %0d writes expected %0d", we_cnt, snap);
        end

        // Randomized loads with SNES traffic and MCU requests
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 16);
            fill_random(len, 1'b1);
            fork
                run_load(len, 3000, "rand");
                snes_gen($urandom_range(8, 12), $urandom_range(0, 12));
                begin
                    repeat ($urandom_range(0, 4)) mcu_write(3'($urandom_range(0, 7)), 32'($urandom), 200);
                end
            join
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
